// File: rtl/zrl_select_scheduler.sv
// Zero-run-length pattern selector: scans per-transformer zero-run lengths and
// picks the longest (ties to the higher index), with fast paths for flagged blocks.
//
// state | meaning
// IDLE  | waiting for a request, ready_o high
// SCAN  | walking transformers one per cycle, tracking the running max
// DONE  | result held on select_o/zrlMax_o until the consumer accepts
module zrl_select_scheduler #(
  parameter int NUM_PATTERNS          = 8,
  parameter int NUM_FIRST_TRANSFORMER = 2,
  parameter int NUM_LAST_TRANSFORMER  = 6,
  localparam int NT         = NUM_LAST_TRANSFORMER - NUM_FIRST_TRANSFORMER + 1,
  localparam int LEN_ENCODE = $clog2(NUM_PATTERNS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  isAllZero_i,
  input  logic                  isAllWordSame_i,
  input  logic [4*NT-1:0]       zeroRunLen_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LEN_ENCODE-1:0] select_o,
  output logic [3:0]            zrlMax_o,
  output logic [15:0]           blkCnt_o
);

  localparam int IDXW = $clog2(NUM_LAST_TRANSFORMER + 1);
  localparam int SELW = (IDXW > LEN_ENCODE) ? IDXW : LEN_ENCODE;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q;
  logic [IDXW-1:0] idx_q;
  logic [SELW-1:0] sel_q;
  logic [3:0]      max_q;
  logic [15:0]     blk_cnt_q;
  logic [4*NT-1:0] zrl_q;
  logic [3:0]      cur_zrl;

  // Lowest transformer index sits in the most significant nibble.
  always_comb begin
    cur_zrl = 4'd0;
    for (int k = 0; k < NT; k++) begin
      if (idx_q == IDXW'(NUM_FIRST_TRANSFORMER + k))
        cur_zrl = zrl_q[4*(NT-k)-1 -: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sel_q     <= SELW'(NUM_PATTERNS - 1);
      max_q     <= 4'd0;
      blk_cnt_q <= 16'd0;
      zrl_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            zrl_q <= zeroRunLen_i;
            if (isAllZero_i) begin
              sel_q   <= SELW'(0);
              max_q   <= 4'd0;
              state_q <= DONE;
            end else if (isAllWordSame_i) begin
              sel_q   <= SELW'(1);
              max_q   <= 4'd0;
              state_q <= DONE;
            end else begin
              max_q   <= 4'd0;
              idx_q   <= IDXW'(NUM_FIRST_TRANSFORMER);
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          // >= so that ties land on the later (higher) transformer.
          if (cur_zrl >= max_q) begin
            max_q <= cur_zrl;
            sel_q <= SELW'(idx_q);
          end
          idx_q <= idx_q + IDXW'(1);
          if (idx_q == IDXW'(NUM_LAST_TRANSFORMER))
            state_q <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            if (blk_cnt_q != 16'hFFFF)
              blk_cnt_q <= blk_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign select_o = sel_q[LEN_ENCODE-1:0];
  assign zrlMax_o = max_q;
  assign blkCnt_o = blk_cnt_q;

endmodule
